// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM states, twiddle format and index helpers for the FFT engine.
package fft_pkg;

    localparam int TW_FRAC = 14;

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} fft_state_e;

    function automatic int bitrev(input int x, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    // Rounded Q1.14 cos/sin of 2*pi*k/n; the caller applies the direction sign to the sine term.
    function automatic int twiddle(input int k, input int n, input bit want_sin);
        real ang, v;
        ang = 2.0 * 3.14159265358979 * real'(k) / real'(n);
        v = (want_sin ? $sin(ang) : $cos(ang)) * real'(1 << TW_FRAC);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 butterfly, a +/- round(W*b) with W in Q1.14.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int TW_WIDTH  = 16
) (
    input  logic signed [OUT_WIDTH-1:0] a_re_i,
    input  logic signed [OUT_WIDTH-1:0] a_im_i,
    input  logic signed [OUT_WIDTH-1:0] b_re_i,
    input  logic signed [OUT_WIDTH-1:0] b_im_i,
    input  logic signed [TW_WIDTH-1:0]  w_re_i,
    input  logic signed [TW_WIDTH-1:0]  w_im_i,
    output logic signed [OUT_WIDTH-1:0] sum_re_o,
    output logic signed [OUT_WIDTH-1:0] sum_im_o,
    output logic signed [OUT_WIDTH-1:0] diff_re_o,
    output logic signed [OUT_WIDTH-1:0] diff_im_o
);
    localparam int PW = OUT_WIDTH + TW_WIDTH + 1;

    logic signed [PW-1:0] p_re, p_im;
    logic signed [OUT_WIDTH-1:0] t_re, t_im;

    always_comb begin
        p_re = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i) + PW'(1 << (TW_FRAC - 1));
        p_im = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i) + PW'(1 << (TW_FRAC - 1));
        t_re = OUT_WIDTH'(p_re >>> TW_FRAC);
        t_im = OUT_WIDTH'(p_im >>> TW_FRAC);
        sum_re_o  = a_re_i + t_re;
        sum_im_o  = a_im_i + t_im;
        diff_re_o = a_re_i - t_re;
        diff_im_o = a_im_i - t_im;
    end

endmodule

// File: rtl/fft_controller.sv
// fft_controller: iterative radix-2 DIT FFT/IFFT, one in-place butterfly per clock over a work array.
module fft_controller
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = 16,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 32,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_fft,
    input  logic                         forward_inverse,
    input  logic signed [DATA_WIDTH-1:0] in_data_real  [FFT_POINTS],
    input  logic signed [DATA_WIDTH-1:0] in_data_imag  [FFT_POINTS],
    output logic signed [OUT_WIDTH-1:0]  out_data_real [FFT_POINTS],
    output logic signed [OUT_WIDTH-1:0]  out_data_imag [FFT_POINTS],
    output logic                         fft_data_valid,
    output logic                         fft_in_prog
);
    localparam int L    = $clog2(FFT_POINTS);
    localparam int HALF = FFT_POINTS / 2;
    localparam int SW   = $clog2(L);

    fft_state_e state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [L-2:0] idx_q, idx_d;
    logic fwd_q, valid_q, accept;
    logic signed [OUT_WIDTH-1:0] work_re_q [FFT_POINTS];
    logic signed [OUT_WIDTH-1:0] work_im_q [FFT_POINTS];
    logic signed [OUT_WIDTH-1:0] out_re_q [FFT_POINTS];
    logic signed [OUT_WIDTH-1:0] out_im_q [FFT_POINTS];
    logic [L-1:0] half, pos, top, bot;
    logic [L-2:0] k;
    logic signed [TW_WIDTH-1:0] cos_rom [HALF];
    logic signed [TW_WIDTH-1:0] sin_rom [HALF];
    logic signed [TW_WIDTH-1:0] w_re, w_im;
    logic signed [OUT_WIDTH-1:0] sum_re, sum_im, diff_re, diff_im;

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        assign cos_rom[g] = TW_WIDTH'(twiddle(g, FFT_POINTS, 1'b0));
        assign sin_rom[g] = TW_WIDTH'(twiddle(g, FFT_POINTS, 1'b1));
    end

    // top = (j>>s)*2*half + pos; pos < half so bot = top + half is a plain OR.
    always_comb begin
        half = L'(1) << stage_q;
        pos  = {1'b0, idx_q} & (half - 1'b1);
        top  = ((({1'b0, idx_q} >> stage_q) << stage_q) << 1) | pos;
        bot  = top | half;
        k    = (L-1)'(pos << (SW'(L - 1) - stage_q));
        w_re = cos_rom[k];
        w_im = fwd_q ? -sin_rom[k] : sin_rom[k];
    end

    fft_butterfly #(.OUT_WIDTH(OUT_WIDTH), .TW_WIDTH(TW_WIDTH)) u_bfly (
        .a_re_i   (work_re_q[top]),
        .a_im_i   (work_im_q[top]),
        .b_re_i   (work_re_q[bot]),
        .b_im_i   (work_im_q[bot]),
        .w_re_i   (w_re),
        .w_im_i   (w_im),
        .sum_re_o (sum_re),
        .sum_im_o (sum_im),
        .diff_re_o(diff_re),
        .diff_im_o(diff_im)
    );

    assign accept = (state_q == IDLE) && start_fft;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: if (start_fft) begin
                state_d = COMPUTE;
                stage_d = '0;
                idx_d   = '0;
            end
            COMPUTE: begin
                idx_d = idx_q + 1'b1;
                if (&idx_q) begin
                    stage_d = stage_q + 1'b1;
                    state_d = (stage_q == SW'(L - 1)) ? OUTPUT : COMPUTE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            idx_q   <= '0;
            fwd_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int n = 0; n < FFT_POINTS; n++) begin
                work_re_q[L'(n)] <= '0;
                work_im_q[L'(n)] <= '0;
                out_re_q[L'(n)]  <= '0;
                out_im_q[L'(n)]  <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            if (accept) begin
                fwd_q   <= forward_inverse;
                valid_q <= 1'b0;
                for (int n = 0; n < FFT_POINTS; n++) begin
                    work_re_q[L'(bitrev(n, L))] <= OUT_WIDTH'(in_data_real[n]);
                    work_im_q[L'(bitrev(n, L))] <= OUT_WIDTH'(in_data_imag[n]);
                end
            end
            if (state_q == COMPUTE) begin
                work_re_q[top] <= sum_re;
                work_im_q[top] <= sum_im;
                work_re_q[bot] <= diff_re;
                work_im_q[bot] <= diff_im;
            end
            // Inverse scaling by 1/N is a floor shift, applied only when publishing.
            if (state_q == OUTPUT) begin
                valid_q <= 1'b1;
                for (int n = 0; n < FFT_POINTS; n++) begin
                    out_re_q[L'(n)] <= fwd_q ? work_re_q[L'(n)] : work_re_q[L'(n)] >>> L;
                    out_im_q[L'(n)] <= fwd_q ? work_im_q[L'(n)] : work_im_q[L'(n)] >>> L;
                end
            end
        end
    end

    assign out_data_real  = out_re_q;
    assign out_data_imag  = out_im_q;
    assign fft_data_valid = valid_q;
    assign fft_in_prog    = state_q != IDLE;

endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: directed and randomized checks of fft_controller against a floating-point DFT model.
module tb_fft_controller;
    localparam int N = 16;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic reset, start_fft, forward_inverse;
    logic signed [23:0] in_re [N];
    logic signed [23:0] in_im [N];
    logic signed [31:0] out_re [N];
    logic signed [31:0] out_im [N];
    logic signed [31:0] save_re [N];
    logic signed [31:0] save_im [N];
    logic valid, in_prog;
    real exp_re [N];
    real exp_im [N];
    int checks = 0;
    int errors = 0;
    int lat, cnt;

    fft_controller #(.FFT_POINTS(N), .DATA_WIDTH(24), .OUT_WIDTH(32), .TW_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_fft      (start_fft),
        .forward_inverse(forward_inverse),
        .in_data_real   (in_re),
        .in_data_imag   (in_im),
        .out_data_real  (out_re),
        .out_data_imag  (out_im),
        .fft_data_valid (valid),
        .fft_in_prog    (in_prog)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b exp %0b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int idx, input real got, input real exp, input real tol);
        checks++;
        assert ((got - exp <= tol) && (exp - got <= tol)) else begin
            errors++;
            $error("FAIL %s[%0d] got %0.1f exp %0.1f tol %0.1f", tag, idx, got, exp, tol);
        end
    endtask

    // Direct O(N^2) DFT of the current inputs; inverse includes the 1/N factor.
    task automatic model(input bit fwd);
        for (int kk = 0; kk < N; kk++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = (fwd ? -2.0 : 2.0) * PI * real'(kk * n) / real'(N);
                sr += real'(in_re[n]) * $cos(ang) - real'(in_im[n]) * $sin(ang);
                si += real'(in_re[n]) * $sin(ang) + real'(in_im[n]) * $cos(ang);
            end
            exp_re[kk] = fwd ? sr : sr / real'(N);
            exp_im[kk] = fwd ? si : si / real'(N);
        end
    endtask

    task automatic chk_all(input string tag, input real tol);
        for (int kk = 0; kk < N; kk++) begin
            chk_near({tag, "_re"}, kk, real'(out_re[kk]), exp_re[kk], tol);
            chk_near({tag, "_im"}, kk, real'(out_im[kk]), exp_im[kk], tol);
        end
    endtask

    function automatic int nonzero_outputs();
        int c = 0;
        for (int kk = 0; kk < N; kk++) c += (out_re[kk] != 0 || out_im[kk] != 0) ? 1 : 0;
        return c;
    endfunction

    function automatic int changed_outputs();
        int c = 0;
        for (int kk = 0; kk < N; kk++) c += (out_re[kk] != save_re[kk] || out_im[kk] != save_im[kk]) ? 1 : 0;
        return c;
    endfunction

    task automatic fill_random(input int amp);
        for (int n = 0; n < N; n++) begin
            in_re[n] = 24'(int'($urandom_range(2 * amp)) - amp);
            in_im[n] = 24'(int'($urandom_range(2 * amp)) - amp);
        end
    endtask

    task automatic launch(input bit fwd);
        forward_inverse = fwd;
        start_fft = 1'b1;
        @(posedge clk);
        #1;
        start_fft = 1'b0;
        chk_bit("inprog_e0", in_prog, 1'b1);
        chk_bit("valid_clr_e0", valid, 1'b0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start_fft = 1'b0;
        forward_inverse = 1'b1;
        for (int n = 0; n < N; n++) begin
            in_re[n] = '0;
            in_im[n] = '0;
        end
        repeat (10) @(posedge clk);
        #1;
        chk_bit("rst_valid", valid, 1'b0);
        chk_bit("rst_inprog", in_prog, 1'b0);
        chk_int("rst_outputs_nonzero", nonzero_outputs(), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < N; n++) in_re[n] = (n % 4 < 2) ? 24'sh400000 : 24'shC00000;
        model(1'b1);
        launch(1'b1);
        wait_valid(lat);
        chk_int("sq_latency", lat, 33);
        chk_bit("sq_inprog_done", in_prog, 1'b0);
        chk_near("sq_x4_re", 4, real'(out_re[4]), 33554432.0, 2.0);
        chk_near("sq_x4_im", 4, real'(out_im[4]), -33554432.0, 2.0);
        chk_near("sq_x12_re", 12, real'(out_re[12]), 33554432.0, 2.0);
        chk_near("sq_x12_im", 12, real'(out_im[12]), 33554432.0, 2.0);
        chk_all("sq", 2.0);
        save_re = out_re;
        save_im = out_im;

        for (int n = 0; n < N; n++) in_re[n] = (n == 0) ? 24'sh100000 : 24'sh0;
        model(1'b1);
        launch(1'b1);
        wait_valid(lat);
        chk_int("imp_latency", lat, 33);
        chk_all("imp", 1.0);

        for (int kk = 0; kk < N; kk++) begin
            in_re[kk] = 24'(save_re[kk] >>> 4);
            in_im[kk] = 24'(save_im[kk] >>> 4);
        end
        model(1'b0);
        launch(1'b0);
        wait_valid(lat);
        chk_int("isq_latency", lat, 33);
        chk_all("isq", 2.0);
        for (int n = 0; n < N; n++) chk_near("isq_pattern", n, real'(out_re[n]), (n % 4 < 2) ? 262144.0 : -262144.0, 2.0);

        fill_random(2047);
        model(1'b1);
        launch(1'b1);
        repeat (9) @(posedge clk);
        #1;
        start_fft = 1'b1;
        forward_inverse = 1'b0;
        fill_random(2047);
        @(posedge clk);
        #1;
        start_fft = 1'b0;
        wait_valid(lat);
        chk_int("busy_latency", lat + 10, 33);
        chk_all("busy", 24.0);
        save_re = out_re;
        save_im = out_im;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1 || in_prog !== 1'b0) cnt++;
        end
        chk_int("busy_single_result", cnt, 0);
        chk_int("hold_outputs_changed", changed_outputs(), 0);

        fill_random(2047);
        launch(1'b1);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_bit("rst_mid_inprog", in_prog, 1'b0);
        chk_bit("rst_mid_valid", valid, 1'b0);
        chk_int("rst_mid_outputs_nonzero", nonzero_outputs(), 0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) cnt++;
        end
        chk_int("rst_mid_no_valid", cnt, 0);
        fill_random(2047);
        model(1'b1);
        launch(1'b1);
        wait_valid(lat);
        chk_int("after_rst_latency", lat, 33);
        chk_all("after_rst", 24.0);

        for (int r = 0; r < 4; r++) begin
            fill_random(2047);
            model(r % 2 == 0);
            launch(r % 2 == 0);
            wait_valid(lat);
            chk_int("rnd_latency", lat, 33);
            chk_all((r % 2 == 0) ? "rnd_fwd" : "rnd_inv", (r % 2 == 0) ? 24.0 : 4.0);
        end

        fill_random(2047);
        model(1'b1);
        forward_inverse = 1'b1;
        start_fft = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("held_inprog_e0", in_prog, 1'b1);
        wait_valid(lat);
        chk_int("held_latency", lat, 33);
        chk_all("held", 24.0);
        @(posedge clk);
        #1;
        chk_bit("held_reaccept_inprog", in_prog, 1'b1);
        chk_bit("held_reaccept_valid", valid, 1'b0);
        start_fft = 1'b0;
        wait_valid(lat);
        chk_int("held_second_latency", lat, 33);
        chk_all("held2", 24.0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
